// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed 33-cycle START-to-DONE latency for every op.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wa,
  output logic        we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        fin_pend;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [31:0] a_raw;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [63:0] prod;
  logic        neg;
  logic        a_neg_q;
  logic        b_zero;

  // Operand signedness decoded straight from funct3 at acceptance time
  logic        signed_a, signed_b, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;

  always_comb begin
    signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg    = signed_a & rs1[31];
    b_neg    = signed_b & rs2[31];
    a_abs    = a_neg ? (32'd0 - rs1) : rs1;
    b_abs    = b_neg ? (32'd0 - rs2) : rs2;
  end

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [63:0] div_next;

  // prod doubles as {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, prod[63:32]} + {1'b0, ma};
    mul_next  = prod[0] ? {mul_sum, prod[31:1]} : {1'b0, prod[63:1]};
    div_trial = {1'b0, prod[62:31]} - {1'b0, mb};
    div_next  = div_trial[32] ? {prod[62:0], 1'b0}
                              : {div_trial[31:0], prod[30:0], 1'b1};
  end

  logic [63:0] prod_signed;
  logic [31:0] quo, rem, final_res;

  always_comb begin
    prod_signed = neg ? (64'd0 - prod) : prod;
    quo         = neg ? (32'd0 - prod[31:0]) : prod[31:0];
    rem         = a_neg_q ? (32'd0 - prod[63:32]) : prod[63:32];
    if (!op[2])
      final_res = (op[1:0] == 2'b00) ? prod_signed[31:0] : prod_signed[63:32];
    else if (b_zero)
      final_res = op[1] ? a_raw : 32'hFFFF_FFFF;
    else
      final_res = op[1] ? rem : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 6'd0;
      fin_pend <= 1'b0;
      op       <= 3'd0;
      rd_q     <= 5'd0;
      a_raw    <= 32'd0;
      ma       <= 32'd0;
      mb       <= 32'd0;
      prod     <= 64'd0;
      neg      <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero   <= 1'b0;
      result   <= 32'd0;
      wa       <= 5'd0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op       <= funct3;
          rd_q     <= rd;
          a_raw    <= rs1;
          ma       <= a_abs;
          mb       <= b_abs;
          neg      <= a_neg ^ b_neg;
          a_neg_q  <= a_neg;
          b_zero   <= (rs2 == 32'd0);
          cnt      <= 6'd0;
          fin_pend <= 1'b0;
          prod     <= funct3[2] ? {32'd0, a_abs} : {32'd0, b_abs};
          state    <= funct3[2] ? S_DIV : S_MUL;
        end
        S_MUL, S_DIV: begin
          if (fin_pend) begin
            // Sign fix-up cycle after the 32 iterations
            result   <= final_res;
            wa       <= rd_q;
            fin_pend <= 1'b0;
            state    <= S_FIN;
          end else begin
            prod <= (state == S_MUL) ? mul_next : div_next;
            if (cnt == 6'd31) fin_pend <= 1'b1;
            else              cnt      <= cnt + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
  assign we   = done;

endmodule
